// File: rtl/bound_flasher_pkg.sv
// Shared phase encoding and thermometer decode for the bound flasher family.
package bound_flasher_pkg;

    localparam int MAX_LED_W = 64;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_UP0  = 3'd1,
        PH_DN0  = 3'd2,
        PH_UP1  = 3'd3,
        PH_DN1  = 3'd4,
        PH_UP2  = 3'd5,
        PH_DN2  = 3'd6
    } phase_t;

    // Bit i is lit iff i < level; callers truncate to their own bar width.
    function automatic logic [MAX_LED_W-1:0] thermo(input logic [7:0] level);
        logic [MAX_LED_W-1:0] t;
        t = '0;
        for (int i = 0; i < MAX_LED_W; i++) begin
            t[i] = (i < int'(level));
        end
        return t;
    endfunction

endpackage

// File: rtl/bf_prescaler.sv
// Free-running step-rate divider: one-cycle step strobe every DIV clocks.
module bf_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic step
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign step = (cnt == TC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bound_flasher_gen.sv
// Six-phase thermometer LED bar sequencer with kickback, auto-repeat and step-rate prescaler.
module bound_flasher_gen
    import bound_flasher_pkg::*;
#(
    parameter int LED_W = 16,
    parameter int PEAK0 = 6,
    parameter int PEAK1 = 11,
    parameter int LOW1  = 5,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    input  logic             auto_rep,
    output logic [LED_W-1:0] led_state,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);

    localparam int LVL_W = $clog2(LED_W + 1);
    localparam logic [LVL_W-1:0] TOP_L   = LVL_W'(LED_W);
    localparam logic [LVL_W-1:0] PEAK0_L = LVL_W'(PEAK0);
    localparam logic [LVL_W-1:0] PEAK1_L = LVL_W'(PEAK1);
    localparam logic [LVL_W-1:0] LOW1_L  = LVL_W'(LOW1);
    localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

    if (LED_W < 2 || LED_W > MAX_LED_W) begin : g_bad_led_w
        $error("bound_flasher_gen: LED_W out of range");
    end
    if (PEAK0 < 1 || PEAK0 > LED_W - 1) begin : g_bad_peak0
        $error("bound_flasher_gen: PEAK0 must be in 1..LED_W-1");
    end
    if (LOW1 < 1 || LOW1 >= PEAK1) begin : g_bad_low1
        $error("bound_flasher_gen: LOW1 must be in 1..PEAK1-1");
    end
    if (PEAK1 >= LED_W) begin : g_bad_peak1
        $error("bound_flasher_gen: PEAK1 must be below LED_W");
    end
    if (DIV < 1) begin : g_bad_div
        $error("bound_flasher_gen: DIV must be at least 1");
    end

    logic             step;
    phase_t           ph_q;
    phase_t           ph_nxt;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_nxt;
    logic [LVL_W-1:0] lvl_up;
    logic [LVL_W-1:0] lvl_dn;
    logic             done_nxt;

    bf_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step)
    );

    assign phase = ph_q;

    // Each phase moves the level one notch; the phase flips on the edge the target is reached.
    always_comb begin
        ph_nxt   = ph_q;
        lvl_nxt  = lvl_q;
        done_nxt = 1'b0;
        lvl_up   = lvl_q + 1'b1;
        lvl_dn   = lvl_q - 1'b1;
        if (step) begin
            case (ph_q)
                PH_IDLE: begin
                    if (flick) begin
                        ph_nxt  = PH_UP0;
                        lvl_nxt = ONE_L;
                    end
                end
                PH_UP0: begin
                    lvl_nxt = lvl_up;
                    if (lvl_up == PEAK0_L) ph_nxt = PH_DN0;
                end
                PH_DN0: begin
                    lvl_nxt = lvl_dn;
                    if (lvl_dn == '0) ph_nxt = PH_UP1;
                end
                PH_UP1: begin
                    lvl_nxt = lvl_up;
                    if (lvl_up == PEAK1_L) ph_nxt = PH_DN1;
                end
                PH_DN1: begin
                    lvl_nxt = lvl_dn;
                    if (lvl_dn == LOW1_L) ph_nxt = flick ? PH_UP1 : PH_UP2;
                end
                PH_UP2: begin
                    lvl_nxt = lvl_up;
                    if (lvl_up == TOP_L) ph_nxt = PH_DN2;
                end
                PH_DN2: begin
                    lvl_nxt = lvl_dn;
                    // Kickback beats auto-repeat, which beats going idle.
                    if (flick && (lvl_dn == LOW1_L || lvl_dn == '0)) begin
                        ph_nxt = PH_UP2;
                    end else if (lvl_dn == '0) begin
                        if (auto_rep) begin
                            ph_nxt = PH_UP0;
                        end else begin
                            ph_nxt   = PH_IDLE;
                            done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    ph_nxt  = PH_IDLE;
                    lvl_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q      <= PH_IDLE;
            lvl_q     <= '0;
            led_state <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ph_q      <= ph_nxt;
            lvl_q     <= lvl_nxt;
            led_state <= LED_W'(thermo(8'(lvl_nxt)));
            busy      <= (ph_nxt != PH_IDLE);
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Directed bench for bound_flasher_gen: vector table plus multi-cycle kickback/auto-repeat/prescaler sequences.
module tb_bound_flasher_gen;

    typedef struct packed {
        logic        rst_n;
        logic        flick;
        logic        auto_rep;
        logic [15:0] led;
        logic [2:0]  ph;
        logic        busy;
        logic        done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, flick, auto_rep;
    logic [15:0] led;
    logic [2:0]  ph;
    logic        busy, done;
    logic        rst_n4, flick4, auto4;
    logic [15:0] led4;
    logic [2:0]  ph4;
    logic        busy4, done4;

    int n_cmp = 0;
    int n_err = 0;
    int s = 0;
    int done_seen = 0;
    int idle_seen = 0;
    vec_t vt [16];

    always #5 clk = ~clk;

    bound_flasher_gen dut (
        .clk (clk), .rst_n (rst_n), .flick (flick), .auto_rep (auto_rep),
        .led_state (led), .phase (ph), .busy (busy), .done (done)
    );

    bound_flasher_gen #(.DIV(4)) dut4 (
        .clk (clk), .rst_n (rst_n4), .flick (flick4), .auto_rep (auto4),
        .led_state (led4), .phase (ph4), .busy (busy4), .done (done4)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flick = 1'b0; auto_rep = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        s = 0;
        done_seen = 0;
    endtask

    task automatic start();
        flick = 1'b1;
        tick();
        flick = 1'b0;
        s = 1;
    endtask

    task automatic run_to(input int target);
        while (s < target) begin
            tick();
            s++;
            done_seen += int'(done);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flick = 1'b1; auto_rep = 1'b0;
        rst_n4 = 1'b0; flick4 = 1'b0; auto4 = 1'b0;

        vt[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 16'h0001, 3'd1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 3'd1, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 16'h0007, 3'd1, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 16'h000F, 3'd1, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 16'h001F, 3'd1, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 16'h003F, 3'd2, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 16'h001F, 3'd2, 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 16'h000F, 3'd2, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 16'h0007, 3'd2, 1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 16'h0003, 3'd2, 1'b1, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 16'h0001, 3'd2, 1'b1, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 16'h0001, 3'd3, 1'b1, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst_n = vt[i].rst_n; flick = vt[i].flick; auto_rep = vt[i].auto_rep;
            tick();
            chk("tbl_led",  i, 32'(led),  32'(vt[i].led));
            chk("tbl_ph",   i, 32'(ph),   32'(vt[i].ph));
            chk("tbl_busy", i, 32'(busy), 32'(vt[i].busy));
            chk("tbl_done", i, 32'(done), 32'(vt[i].done));
        end
        flick = 1'b0;
        s = 13;
        done_seen = 0;

        // Rest of the single full pass.
        run_to(23); chk("pass_peak1_led", s, 32'(led), 32'h07FF); chk("pass_peak1_ph", s, 32'(ph), 32'd4);
        run_to(29); chk("pass_low1_led", s, 32'(led), 32'h001F);  chk("pass_low1_ph", s, 32'(ph), 32'd5);
        run_to(40); chk("pass_full_led", s, 32'(led), 32'hFFFF);  chk("pass_full_ph", s, 32'(ph), 32'd6);
        run_to(56);
        chk("pass_end_led", s, 32'(led), 32'h0000); chk("pass_end_ph", s, 32'(ph), 32'd0);
        chk("pass_end_busy", s, 32'(busy), 32'd0);  chk("pass_end_done", s, 32'(done), 32'd1);
        run_to(57);
        chk("pass_after_done", s, 32'(done), 32'd0); chk("pass_after_ph", s, 32'(ph), 32'd0);
        chk("pass_done_count", s, done_seen, 1);

        // Kickback in DN1: flick held keeps bouncing between LOW1 and PEAK1.
        do_reset(); start(); run_to(23);
        flick = 1'b1;
        run_to(29); chk("kick_dn1_led", s, 32'(led), 32'h001F); chk("kick_dn1_ph", s, 32'(ph), 32'd3);
        run_to(30); chk("kick_dn1_next", s, 32'(led), 32'h003F); chk("kick_dn1_next_ph", s, 32'(ph), 32'd3);

        // Kickback in DN2 at LOW1, repeatedly, never returning to idle.
        do_reset(); start(); run_to(40);
        flick = 1'b1;
        run_to(51); chk("kick_dn2_led", s, 32'(led), 32'h001F); chk("kick_dn2_ph", s, 32'(ph), 32'd5);
        run_to(62); chk("kick_dn2_top", s, 32'(led), 32'hFFFF); chk("kick_dn2_top_ph", s, 32'(ph), 32'd6);
        idle_seen = 0;
        for (int k = 0; k < 60; k++) begin
            tick(); s++;
            done_seen += int'(done);
            if (!busy) idle_seen++;
        end
        chk("kick_dn2_never_idle", s, idle_seen, 0);
        chk("kick_dn2_no_done", s, done_seen, 0);
        flick = 1'b0;

        // Flick exactly at the DN2 trough kicks back from level 0.
        do_reset(); start(); run_to(55);
        flick = 1'b1; run_to(56); flick = 1'b0;
        chk("kick_zero_led", s, 32'(led), 32'h0000); chk("kick_zero_ph", s, 32'(ph), 32'd5);
        chk("kick_zero_done", s, 32'(done), 32'd0);
        run_to(57); chk("kick_zero_next", s, 32'(led), 32'h0001); chk("kick_zero_next_ph", s, 32'(ph), 32'd5);

        // Auto-repeat restarts at UP0 without a done pulse.
        do_reset(); auto_rep = 1'b1; start();
        run_to(56);
        chk("auto_ph", s, 32'(ph), 32'd1); chk("auto_led", s, 32'(led), 32'h0000);
        chk("auto_busy", s, 32'(busy), 32'd1); chk("auto_done", s, 32'(done), 32'd0);
        run_to(57); chk("auto_next_led", s, 32'(led), 32'h0001);
        chk("auto_no_done", s, done_seen, 0);
        auto_rep = 1'b0;

        // DIV=4 instance: steps on every 4th edge after reset release.
        rst_n4 = 1'b1; flick4 = 1'b1;
        tick(); tick(); tick();
        chk("div4_pre_led", 3, 32'(led4), 32'h0000); chk("div4_pre_ph", 3, 32'(ph4), 32'd0);
        tick();
        chk("div4_first_led", 4, 32'(led4), 32'h0001); chk("div4_first_ph", 4, 32'(ph4), 32'd1);
        flick4 = 1'b0;
        tick(); tick(); tick();
        chk("div4_hold_led", 7, 32'(led4), 32'h0001);
        tick();
        chk("div4_second_led", 8, 32'(led4), 32'h0003);
        for (int e = 9; e <= 56; e++) tick();
        chk("div4_up1_led", 56, 32'(led4), 32'h0003); chk("div4_up1_ph", 56, 32'(ph4), 32'd3);
        rst_n4 = 1'b0;
        tick();
        chk("div4_rst_led", 57, 32'(led4), 32'h0000); chk("div4_rst_ph", 57, 32'(ph4), 32'd0);
        chk("div4_rst_busy", 57, 32'(busy4), 32'd0);  chk("div4_rst_done", 57, 32'(done4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
